// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM encoding and default geometry.
package program_loader_pkg;

  localparam int unsigned LOADER_DEPTH  = 16;
  localparam int unsigned LOADER_ADDR_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCEPT,
    WRITE,
    FILL
  } state_t;

endpackage

// File: rtl/program_loader.sv
// Program loader: streams host bytes into the CPU RAM, zero-fills the tail
// after an early in_last, and holds the CPU in reset until the image is complete.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned DEPTH  = LOADER_DEPTH,
  parameter int unsigned ADDR_W = LOADER_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_we,
  output logic              cpu_hold,
  output logic              done,
  output logic              overrun
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] addr;
  logic              last_q;
  logic              at_last;

  // Completion is decided on the final address, so the counter never wraps.
  always_comb begin
    at_last = (addr == LAST_ADDR);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and per-state strobes.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    mem_we     = 1'b0;
    cpu_hold   = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = ACCEPT;
      end
      ACCEPT: begin
        cpu_hold = 1'b1;
        in_ready = 1'b1;
        if (in_valid) state_next = WRITE;
      end
      WRITE: begin
        cpu_hold = 1'b1;
        mem_we   = 1'b1;
        if (at_last)     state_next = IDLE;
        else if (last_q) state_next = FILL;
        else             state_next = ACCEPT;
      end
      FILL: begin
        cpu_hold = 1'b1;
        mem_we   = 1'b1;
        if (at_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Address counter, registered RAM port, and done/overrun flags.
  // mem_data is cleared once each write pulse is issued so it reads 0x00
  // whenever mem_we is low; FILL then simply advances mem_addr.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr     <= '0;
      last_q   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      done     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            addr    <= '0;
            done    <= 1'b0;
            overrun <= 1'b0;
          end else if (in_valid && done) begin
            overrun <= 1'b1;
          end
        end
        ACCEPT: begin
          if (in_valid) begin
            mem_addr <= addr;
            mem_data <= in_data;
            last_q   <= in_last;
          end
        end
        WRITE: begin
          mem_data <= '0;
          if (at_last) begin
            done <= 1'b1;
          end else begin
            addr <= addr + 1'b1;
            if (last_q) mem_addr <= addr + 1'b1;
          end
        end
        FILL: begin
          if (at_last) begin
            done <= 1'b1;
          end else begin
            addr     <= addr + 1'b1;
            mem_addr <= addr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, the number of RAM bytes to load.
REQ-002 The block SHALL have parameter ADDR_W, default 4, the RAM address width, with DEPTH == 2**ADDR_W.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock shared with the CPU core.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  one-cycle pulse that begins a load; sampled only in IDLE.
REQ-007 in_valid  input  1  a byte is presented on in_data.
REQ-008 in_data  input  8  program byte, sourced from ui_in.
REQ-009 in_last  input  1  qualifies in_data as the final byte supplied by the host.
REQ-010 in_ready  output  1  the loader accepts in_data this cycle.
REQ-011 mem_addr  output  ADDR_W  RAM write address.
REQ-012 mem_data  output  8  RAM write data.
REQ-013 mem_we  output  1  one-cycle RAM write strobe, active-high.
REQ-014 cpu_hold  output  1  holds the CPU core in reset while high.
REQ-015 done  output  1  the load completed; stays high until the next start or rst.
REQ-016 overrun  output  1  sticky flag: the host offered bytes beyond DEPTH.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, ACCEPT, WRITE, FILL.
REQ-018 IDLE: in_ready=0, mem_we=0, cpu_hold=0; start=1 clears done and overrun, zeroes the address counter, and moves to ACCEPT.
REQ-019 ACCEPT: cpu_hold=1 and in_ready=1; a byte transfers only when in_valid&&in_ready, latching in_data, in_last and the current address, then the FSM moves to WRITE.
REQ-020 WRITE: mem_we=1 for exactly one cycle with the latched address and data, and in_ready=0.
REQ-021 Throughput SHALL be one byte per two cycles; the mem_we pulse SHALL follow the accepting edge by exactly one cycle.
REQ-022 From WRITE, the FSM SHALL go to IDLE with done=1 if the address was DEPTH-1.
REQ-023 From WRITE, the FSM SHALL go to FILL if the latched in_last=1 and the address is below DEPTH-1.
REQ-024 From WRITE in all other cases, the FSM SHALL increment the address and return to ACCEPT.
REQ-025 FILL: mem_we=1 and mem_data=0x00 every cycle while the address increments, from (last address+1) through DEPTH-1; after writing DEPTH-1 the FSM goes to IDLE with done=1.
REQ-026 The address counter SHALL be ADDR_W bits; it SHALL never wrap during a load, since completion is taken at DEPTH-1.
REQ-027 in_last on the byte at address DEPTH-1 SHALL complete the load with no fill cycles.
REQ-028 After done, in_valid=1 in IDLE SHALL set overrun=1 and be ignored, with in_ready staying 0.
REQ-029 start while not in IDLE SHALL be ignored.
REQ-030 mem_addr and mem_data SHALL be registered outputs; mem_data SHALL be 0x00 whenever mem_we=0.
REQ-031 cpu_hold SHALL fall on the same edge that done rises.

Reset
REQ-032 rst SHALL, on a rising clk edge, force IDLE, address 0, mem_we=0, mem_addr=0, mem_data=0, in_ready=0, done=0, overrun=0, cpu_hold=0.
REQ-033 rst asserted mid-load SHALL abort immediately with no further mem_we pulse, and the partially written RAM contents SHALL be left as written.
REQ-034 rst SHALL take priority over start and over in_valid.

Structure
REQ-035 A shared package SHALL hold the state enum (IDLE, ACCEPT, WRITE, FILL), LOADER_DEPTH=16 and LOADER_ADDR_W=4.
REQ-036 The design SHALL be a single module with no sub-modules; the address counter and FSM are inline.

Verification
REQ-037 Full load: start, then 16 bytes 0x10..0x1F with in_valid held high -> 16 mem_we pulses at addresses 0..15 with matching data, one every 2 cycles, then done=1 and cpu_hold=0.
REQ-038 Short program: bytes 0xA1, 0xB2, 0xC3 with in_last on 0xC3 -> writes at addresses 0..2, then 13 consecutive 0x00 writes at addresses 3..15, then done=1.
REQ-039 Backpressure: in_valid toggles randomly -> no byte is lost or duplicated, and the RAM image matches the input stream.
REQ-040 Mid-load reset: rst after the 5th accepted byte -> no further mem_we, all outputs at reset values, and a fresh start reloads from address 0.
REQ-041 Overrun: a 17th byte offered after done -> overrun=1, in_ready=0, no mem_we.
REQ-042 Boundary: in_last on the 16th byte -> done with zero FILL cycles; start during ACCEPT -> ignored.
